// File: rtl/bin_to_seg6_pkg.sv
// rtl/bin_to_seg6_pkg.sv - shared states, segment constants and digit table for bin_to_seg6
package bin_to_seg6_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ENCODE = 2'd2
    } state_e;

    localparam logic [7:0]  SEG_BLANK   = 8'h00;
    localparam logic [7:0]  SEG_DASH    = 8'h02;
    localparam logic [23:0] MAX_DISPLAY = 24'd999999;

    // Segment order a,b,c,d,e,f,g,dp from bit 7 down; dp never lit.
    localparam logic [7:0] SEG_TABLE [0:9] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
        8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6
    };

endpackage

// File: rtl/seg7_digit_enc.sv
// rtl/seg7_digit_enc.sv - combinational BCD digit to 7-segment byte encoder with blanking
module seg7_digit_enc
    import bin_to_seg6_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (bcd <= 4'd9)) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/bin_to_seg6.sv
// rtl/bin_to_seg6.sv - binary to six-digit 7-segment converter (iterative double-dabble)
// Build option: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bin_to_seg6
    import bin_to_seg6_pkg::*;
#(
    parameter int BIN_W = 20
) (
    input  logic             s_clk,
    input  logic             s_reset,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [47:0]      seg_data,
    output logic             seg_valid,
    output logic             overflow
);

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [47:0] SEG_RESET = 48'h0000000000FC;
`else
    localparam logic [47:0] SEG_RESET = 48'hFCFCFCFCFCFC;
`endif

    state_e           state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [23:0]      bcd_q, bcd_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [47:0]      seg_data_q, seg_data_d;
    logic             seg_valid_q, seg_valid_d;
    logic             overflow_q, overflow_d;

    logic [23:0]      bcd_adj;
    logic [5:0]       blank;
    logic [47:0]      seg_enc;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 6; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // A digit is blanked only if it and every digit to its left are zero.
    always_comb begin
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        blank[5] = (bcd_q[23:20] == 4'd0);
        for (int i = 4; i >= 1; i--) begin
            blank[i] = blank[i+1] && (bcd_q[i*4 +: 4] == 4'd0);
        end
`endif
    end

    for (genvar g = 0; g < 6; g++) begin : g_enc
        seg7_digit_enc u_enc (
            .bcd   (bcd_q[g*4 +: 4]),
            .blank (blank[g]),
            .seg   (seg_enc[g*8 +: 8])
        );
    end

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        ovf_pend_d  = ovf_pend_q;
        seg_data_d  = seg_data_q;
        seg_valid_d = 1'b0;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d      = bin_in;
                    bcd_d      = '0;
                    cnt_d      = 5'(BIN_W - 1);
                    ovf_pend_d = (24'(bin_in) > MAX_DISPLAY);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj[22:0], bin_q[BIN_W-1]};
                bin_d = bin_q << 1;
                if (cnt_q == 5'd0) begin
                    state_d = ENCODE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ENCODE: begin
                seg_data_d  = ovf_pend_q ? {6{SEG_DASH}} : seg_enc;
                overflow_d  = ovf_pend_q;
                seg_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_clk or negedge s_reset) begin
        if (!s_reset) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            ovf_pend_q  <= 1'b0;
            seg_data_q  <= SEG_RESET;
            seg_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            ovf_pend_q  <= ovf_pend_d;
            seg_data_q  <= seg_data_d;
            seg_valid_q <= seg_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign seg_data  = seg_data_q;
    assign seg_valid = seg_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_bin_to_seg6.sv
// tb/tb_bin_to_seg6.sv - directed self-checking bench for bin_to_seg6
module tb_bin_to_seg6;

    localparam int BIN_W = 20;

    logic             s_clk = 1'b0;
    logic             s_reset = 1'b0;
    logic [BIN_W-1:0] bin_in = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [47:0]      seg_data;
    logic             seg_valid;
    logic             overflow;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [47:0] E_RST   = 48'h0000000000FC;
    localparam logic [47:0] E_12345 = 48'h0060DAF266B6;
    localparam logic [47:0] E_7     = 48'h0000000000E0;
    localparam logic [47:0] E_1     = 48'h000000000060;
    localparam logic [47:0] E_2     = 48'h0000000000DA;
    localparam logic [47:0] E_3     = 48'h0000000000F2;
`else
    localparam logic [47:0] E_RST   = 48'hFCFCFCFCFCFC;
    localparam logic [47:0] E_12345 = 48'hFC60DAF266B6;
    localparam logic [47:0] E_7     = 48'hFCFCFCFCFCE0;
    localparam logic [47:0] E_1     = 48'hFCFCFCFCFC60;
    localparam logic [47:0] E_2     = 48'hFCFCFCFCFCDA;
    localparam logic [47:0] E_3     = 48'hFCFCFCFCFCF2;
`endif

    bin_to_seg6 #(.BIN_W(BIN_W)) dut (
        .s_clk     (s_clk),
        .s_reset   (s_reset),
        .bin_in    (bin_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .seg_data  (seg_data),
        .seg_valid (seg_valid),
        .overflow  (overflow)
    );

    always #5 s_clk = ~s_clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle request; returns edges from acceptance to seg_valid and in_ready-low samples.
    task automatic convert(input logic [BIN_W-1:0] v, output int lat, output int low);
        @(negedge s_clk);
        bin_in   = v;
        in_valid = 1'b1;
        @(posedge s_clk);
        #1 in_valid = 1'b0;
        lat = -1;
        low = 0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                @(posedge s_clk);
                #1;
            end
            if (!in_ready) low++;
            if (seg_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_one(input string tag, input logic [BIN_W-1:0] v,
                           input logic [47:0] exp_seg, input logic exp_ovf);
        int lat, low;
        convert(v, lat, low);
        chk({tag, " latency"}, 48'(lat), 48'd21);
        chk({tag, " busy"}, 48'(low), 48'd21);
        chk({tag, " seg"}, seg_data, exp_seg);
        chk({tag, " ovf"}, 48'(overflow), 48'(exp_ovf));
        @(posedge s_clk);
        #1;
        chk({tag, " pulse"}, 48'(seg_valid), 48'd0);
        chk({tag, " hold"}, seg_data, exp_seg);
    endtask

    initial begin
        logic [BIN_W-1:0] vals [0:2];
        logic [47:0]      exps [0:2];
        int idx, last;
        bit pend;
        vals = '{20'd1, 20'd2, 20'd3};
        exps = '{E_1, E_2, E_3};

        #12;
        chk("rst seg", seg_data, E_RST);
        chk("rst ready", 48'(in_ready), 48'd1);
        chk("rst valid", 48'(seg_valid), 48'd0);
        chk("rst ovf", 48'(overflow), 48'd0);
        @(negedge s_clk);
        s_reset = 1'b1;

        run_one("v12345", 20'd12345, E_12345, 1'b0);
        run_one("v999999", 20'd999999, 48'hF6F6F6F6F6F6, 1'b0);
        run_one("v1000000", 20'd1000000, 48'h020202020202, 1'b1);
        repeat (3) @(posedge s_clk);
        #1 chk("ovf held", 48'(overflow), 48'd1);
        run_one("v7", 20'd7, E_7, 1'b0);
        run_one("v100000", 20'd100000, 48'h60FCFCFCFCFC, 1'b0);

        // in_valid held high; bin_in carries junk while busy to expose any restart.
        @(negedge s_clk);
        bin_in   = vals[0];
        in_valid = 1'b1;
        @(posedge s_clk);
        #1 bin_in = '1;
        idx  = 0;
        last = 0;
        pend = 1'b0;
        for (int c = 1; c <= 100 && idx < 3; c++) begin
            @(posedge s_clk);
            #1;
            if (seg_valid) begin
                chk($sformatf("b2b seg%0d", idx), seg_data, exps[idx]);
                chk($sformatf("b2b ovf%0d", idx), 48'(overflow), 48'd0);
                if (idx > 0) chk($sformatf("b2b gap%0d", idx), 48'(c - last), 48'd22);
                last = c;
                idx++;
                if (idx < 3) begin
                    bin_in = vals[idx];
                    pend   = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end else if (pend) begin
                bin_in = '1;
                pend   = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("b2b count", 48'(idx), 48'd3);

        run_one("v1000000b", 20'd1000000, 48'h020202020202, 1'b1);

        // Asynchronous reset between edges during SHIFT.
        @(negedge s_clk);
        bin_in   = 20'd543210;
        in_valid = 1'b1;
        @(posedge s_clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge s_clk);
        #2 s_reset = 1'b0;
        #1;
        chk("mid rst seg", seg_data, E_RST);
        chk("mid rst ready", 48'(in_ready), 48'd1);
        chk("mid rst valid", 48'(seg_valid), 48'd0);
        chk("mid rst ovf", 48'(overflow), 48'd0);
        idx = 0;
        repeat (3) begin
            @(posedge s_clk);
            #1 if (seg_valid) idx++;
        end
        @(negedge s_clk);
        s_reset = 1'b1;
        repeat (25) begin
            @(posedge s_clk);
            #1 if (seg_valid) idx++;
        end
        chk("mid rst no pulse", 48'(idx), 48'd0);
        run_one("v543210", 20'd543210, 48'hB666F2DA60FC, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bin_to_seg6.md
Name: bin_to_seg6

Overview:
- Upstream feeder for the six-digit 74HC595 display driver.
- Accepts an unsigned binary value over a valid/ready handshake and converts it to six BCD digits with an iterative double-dabble engine.
- Encodes each digit to a 7-segment byte and holds the resulting 48-bit pattern stable on seg_data for the shift-register controller's data_in.

Parameters:
- BIN_W, 20, width of the binary input; range 20..24. Values above 999999 are reported as overflow.

Ports:
- s_clk  input  1  system clock
- s_reset  input  1  asynchronous, active-low reset
- bin_in  input  BIN_W  unsigned value to display
- in_valid  input  1  bin_in is valid
- in_ready  output  1  block is idle and can accept a value
- seg_data  output  48  segment patterns; [47:40] is the leftmost (most significant) digit, [7:0] the rightmost
- seg_valid  output  1  one-cycle pulse when seg_data updates
- overflow  output  1  last accepted value exceeded 999999; held until the next update

Behaviour:
- Reset is asynchronous, asserts on s_reset=0 and overrides all activity, including an in-flight conversion. Reset values:
  - state=IDLE, in_ready=1, seg_valid=0, overflow=0.
  - seg_data = encoding of the value 0 in the current build mode: 48'hFCFCFCFCFCFC, or 48'h0000000000FC with blanking.
- Segment byte format: bit7..0 = a,b,c,d,e,f,g,dp; active-high; dp is always 0.
- Digit codes:
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6
  - blank=00, dash=02
- FSM states: IDLE, SHIFT, ENCODE.
  - IDLE: in_ready=1. On in_valid=1 at edge T, capture bin_in, clear the 24-bit BCD accumulator, load bit counter = BIN_W-1, go to SHIFT.
  - SHIFT: each edge does the add-3 correction on every nibble >=5, then shifts one input bit (MSB first) into the accumulator. After BIN_W edges go to ENCODE.
  - ENCODE: one edge. Registers seg_data and overflow, pulses seg_valid=1 for exactly one cycle, returns to IDLE.
- Latency: seg_data and seg_valid change at edge T+BIN_W+1. With BIN_W=20, seg_valid is high during the cycle after edge T+21.
- in_ready=0 in SHIFT and ENCODE. in_valid is ignored there; no queuing, no back-pressure beyond in_ready.
- Overflow: the captured value is compared against 999999 at capture time.
  - If greater, ENCODE writes all six digits as dash (48'h020202020202) and sets overflow=1.
  - Otherwise overflow=0.
- seg_data holds its value between updates and never shows partial results.
- Back-to-back operation: in_valid held high starts the next conversion at the edge after ENCODE, so the sustained rate is one result per BIN_W+2 cycles.
- Reset mid-SHIFT: the conversion is discarded and seg_data returns to its reset value.

Optional Feature:
- LEADING_ZERO_BLANK_EN
  - Defined: leading zero digits are replaced with blank (00). The rightmost digit is never blanked, so the value 0 shows a single "0". Overflow dashes are not blanked.
  - Undefined: all six digits are always shown, including leading zeros.
  - The reset value of seg_data follows the same rule.

Decomposition:
- Package bin_to_seg6_pkg holds:
  - the state enum (IDLE/SHIFT/ENCODE)
  - the SEG_BLANK=8'h00 and SEG_DASH=8'h02 constants
  - MAX_DISPLAY=999999
  - a constant 10-entry digit-to-segment table
- Sub-module seg7_digit_enc: purely combinational 4-bit BCD to 8-bit segment encoder with a blank input. Instantiate it six times in ENCODE-path logic.
- The top level of this block is the FSM plus the double-dabble datapath.

Test Plan:
- Reset, no blanking: seg_data=48'hFCFCFCFCFCFC, in_ready=1, seg_valid=0, overflow=0. With LEADING_ZERO_BLANK_EN: 48'h0000000000FC.
- bin_in=12345 with one-cycle in_valid:
  - in_ready=0 for 21 cycles, then a single seg_valid pulse 21 edges after acceptance.
  - seg_data=48'hFC60DAF266B6, or 48'h0060DAF266B6 with blanking.
- bin_in=999999 -> seg_data=48'hF6F6F6F6F6F6, overflow=0. Then bin_in=1000000 -> 48'h020202020202, overflow=1. Then bin_in=7 -> overflow=0 and seg_data=48'hFCFCFCFCFCE0 (blanked build: 48'h0000000000E0).
- in_valid held high with values 1, 2, 3 -> three results, each exactly 22 cycles apart; in_valid asserted during SHIFT does not restart or corrupt the conversion.
- Assert s_reset asynchronously (between clock edges) mid-SHIFT of 543210 -> outputs return to reset values immediately; no seg_valid pulse. A new request after release converts 543210 correctly to 48'hB666F2DA60FC.
- bin_in=100000 with blanking -> 48'h60FCFCFCFCFC; inner zeros are not blanked.
